// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush sequencer for the vector ASIP pipeline. It drives the
//   enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and
//   the PC enable. It handles memory wait states, multi-cycle vector ops in EX,
//   load-use hazards, taken branches and the halt/drain sequence.
//   State updates on posedge clk. The pipeline registers capture on negedge, so
//   the combinational enables settle half a cycle before they are used.
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   start               leave IDLE and begin fetching
//   mem_busy            data memory not ready, freeze the whole pipeline
//   vec_start           multi-cycle vector op in EX this cycle
//   vec_cycles          total EX cycles for that op
//   load_use            ID consumer depends on a load currently in EX
//   branch_taken        branch resolved taken in EX
//   halt_ex             halt instruction in EX
//   pc_en, en_*         PC and pipeline register enables
//   flush_*             load a bubble into that register when enabled
//   done                pipeline fully drained after halt
//   stall_cycles        saturating count of stalled cycles while running
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int VCNT_W = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_busy,
  input  logic              vec_start,
  input  logic [VCNT_W-1:0] vec_cycles,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic              halt_ex,
  output logic              pc_en,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              done,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_VEC_BUSY = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_DRAIN    = 3'd4,
    S_HALTED   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic [PERF_W-1:0]   stall_q, stall_d;

  logic pc_en_s, en_if_id_s, en_id_ex_s, en_ex_mem_s, en_mem_wb_s;
  logic flush_if_id_s, flush_id_ex_s, flush_ex_mem_s, done_s;
  logic stall_track_s;

  // Next-state, counter and output decode from the current state and inputs.
  always_comb begin
    state_d        = state_q;
    vcnt_d         = vcnt_q;
    dcnt_d         = dcnt_q;
    pc_en_s        = 1'b0;
    en_if_id_s     = 1'b0;
    en_id_ex_s     = 1'b0;
    en_ex_mem_s    = 1'b0;
    en_mem_wb_s    = 1'b0;
    flush_if_id_s  = 1'b0;
    flush_id_ex_s  = 1'b0;
    flush_ex_mem_s = 1'b0;
    done_s         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      // MEM_WAIT with memory ready is evaluated exactly like RUN, and a busy
      // memory in RUN is the same full freeze as staying in MEM_WAIT.
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          state_d = S_MEM_WAIT;
        end else begin
          state_d     = S_RUN;
          pc_en_s     = 1'b1;
          en_if_id_s  = 1'b1;
          en_id_ex_s  = 1'b1;
          en_ex_mem_s = 1'b1;
          en_mem_wb_s = 1'b1;
          if (vec_start) begin
            // A 0/1-cycle vector op completes in one cycle: plain RUN default.
            if (vec_cycles >= VCNT_W'(2)) begin
              pc_en_s        = 1'b0;
              en_if_id_s     = 1'b0;
              en_id_ex_s     = 1'b0;
              flush_ex_mem_s = 1'b1;
              vcnt_d         = vec_cycles - VCNT_W'(2);
              state_d        = S_VEC_BUSY;
            end else begin
              state_d = S_RUN;
            end
          end else if (halt_ex) begin
            pc_en_s       = 1'b0;
            en_if_id_s    = 1'b0;
            flush_id_ex_s = 1'b1;
            dcnt_d        = 2'd2;
            state_d       = S_DRAIN;
          end else if (load_use) begin
            pc_en_s       = 1'b0;
            en_if_id_s    = 1'b0;
            flush_id_ex_s = 1'b1;
          end else if (branch_taken) begin
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_VEC_BUSY: begin
        if (mem_busy) begin
          state_d = S_VEC_BUSY;
        end else begin
          pc_en_s     = 1'b1;
          en_if_id_s  = 1'b1;
          en_id_ex_s  = 1'b1;
          en_ex_mem_s = 1'b1;
          en_mem_wb_s = 1'b1;
          if (vcnt_q != {VCNT_W{1'b0}}) begin
            pc_en_s        = 1'b0;
            en_if_id_s     = 1'b0;
            en_id_ex_s     = 1'b0;
            flush_ex_mem_s = 1'b1;
            vcnt_d         = vcnt_q - VCNT_W'(1);
          end else begin
            // Final iteration: EX/MEM captures the real vector result.
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          state_d = S_DRAIN;
        end else begin
          en_id_ex_s    = 1'b1;
          en_ex_mem_s   = 1'b1;
          en_mem_wb_s   = 1'b1;
          flush_id_ex_s = 1'b1;
          if (dcnt_q != 2'd0) begin
            dcnt_d = dcnt_q - 2'd1;
          end else begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        done_s  = 1'b1;
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stall counting only covers the running states; drain/halt are not stalls.
  always_comb begin
    stall_track_s = (state_q == S_RUN) || (state_q == S_VEC_BUSY) ||
                    (state_q == S_MEM_WAIT);
    if (stall_track_s && !pc_en_s && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + PERF_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vcnt_q  <= {VCNT_W{1'b0}};
      dcnt_q  <= 2'd0;
      stall_q <= {PERF_W{1'b0}};
    end else begin
      state_q <= state_d;
      vcnt_q  <= vcnt_d;
      dcnt_q  <= dcnt_d;
      stall_q <= stall_d;
    end
  end

  assign pc_en        = pc_en_s;
  assign en_if_id     = en_if_id_s;
  assign en_id_ex     = en_id_ex_s;
  assign en_ex_mem    = en_ex_mem_s;
  assign en_mem_wb    = en_mem_wb_s;
  assign flush_if_id  = flush_if_id_s;
  assign flush_id_ex  = flush_id_ex_s;
  assign flush_ex_mem = flush_ex_mem_s;
  assign done         = done_s;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl. Each cycle the stimulus and its
//   expected output vector / stall count are pushed to a queue; on the falling
//   edge the entry is popped and compared. A second instance with a 3-bit
//   stall counter runs in lockstep to exercise saturation.
//   Output vector order: {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
//                         flush_if_id, flush_id_ex, flush_ex_mem, done}
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam logic [8:0] O_ZERO = 9'b000000000;
  localparam logic [8:0] O_RUN  = 9'b111110000;
  localparam logic [8:0] O_VEC  = 9'b000110010;
  localparam logic [8:0] O_HZ   = 9'b001110100;
  localparam logic [8:0] O_BR   = 9'b111111100;
  localparam logic [8:0] O_HALT = 9'b000000001;

  logic       clk;
  logic       reset;
  logic       start, mem_busy, vec_start, load_use, branch_taken, halt_ex;
  logic [3:0] vec_cycles;

  logic        pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, done;
  logic [15:0] stall_cycles;

  logic        pc_en2, en_if_id2, en_id_ex2, en_ex_mem2, en_mem_wb2;
  logic        flush_if_id2, flush_id_ex2, flush_ex_mem2, done2;
  logic [2:0]  stall_cycles2;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [8:0] outs;
    int         stall;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  pipeline_ctrl #(.VCNT_W(4), .PERF_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_busy(mem_busy),
    .vec_start(vec_start), .vec_cycles(vec_cycles), .load_use(load_use),
    .branch_taken(branch_taken), .halt_ex(halt_ex), .pc_en(pc_en),
    .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .done(done),
    .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.VCNT_W(4), .PERF_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .mem_busy(mem_busy),
    .vec_start(vec_start), .vec_cycles(vec_cycles), .load_use(load_use),
    .branch_taken(branch_taken), .halt_ex(halt_ex), .pc_en(pc_en2),
    .en_if_id(en_if_id2), .en_id_ex(en_id_ex2), .en_ex_mem(en_ex_mem2),
    .en_mem_wb(en_mem_wb2), .flush_if_id(flush_if_id2),
    .flush_id_ex(flush_id_ex2), .flush_ex_mem(flush_ex_mem2), .done(done2),
    .stall_cycles(stall_cycles2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pop one scoreboard entry and compare both instances against it.
  task automatic compare_now();
    exp_t e;
    int   sat;
    e   = sb_q.pop_front();
    sat = (e.stall > 7) ? 7 : e.stall;
    check_eq({e.tag, "_out"}, 32'({pc_en, en_if_id, en_id_ex, en_ex_mem,
             en_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, done}),
             32'(e.outs));
    check_eq({e.tag, "_stall"}, 32'(stall_cycles), 32'(e.stall));
    check_eq({e.tag, "_out_sat"}, 32'({pc_en2, en_if_id2, en_id_ex2,
             en_ex_mem2, en_mem_wb2, flush_if_id2, flush_id_ex2,
             flush_ex_mem2, done2}), 32'(e.outs));
    check_eq({e.tag, "_stall_sat"}, 32'(stall_cycles2), 32'(sat));
  endtask

  // One clock cycle: drive just after posedge, check on negedge.
  task automatic step(input string tag, input logic st, input logic mb,
                      input logic vs, input logic [3:0] vc, input logic lu,
                      input logic br, input logic hx, input logic [8:0] eo,
                      input int es);
    start        = st;
    mem_busy     = mb;
    vec_start    = vs;
    vec_cycles   = vc;
    load_use     = lu;
    branch_taken = br;
    halt_ex      = hx;
    sb_q.push_back('{eo, es, tag});
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    start        = 1'b0;
    mem_busy     = 1'b0;
    vec_start    = 1'b0;
    vec_cycles   = 4'd0;
    load_use     = 1'b0;
    branch_taken = 1'b0;
    halt_ex      = 1'b0;

    // Reset held: everything zero.
    repeat (2) @(posedge clk);
    sb_q.push_back('{O_ZERO, 0, "reset"});
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
    reset = 1'b0;

    //     tag        st    mb    vs    vc     lu    br    hx    out     stall
    step("idle",     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("start",    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("run",      1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  0);
    // Vector op of 4 cycles: three stall cycles, then real result.
    step("vec4_0",   1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, O_VEC,  0);
    step("vec4_1",   1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b1, O_VEC,  1);
    step("vec4_2",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  2);
    step("vec4_3",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  3);
    step("vec4_run", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  3);
    // mem_busy for 5 cycles with vec_start in the first; vec honoured after.
    step("mb_0",     1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, O_ZERO, 3);
    for (int i = 1; i < 5; i++) begin
      step("mb_n",   1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, O_ZERO, 3 + i);
    end
    step("mb_vec0",  1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, O_VEC,  8);
    step("mb_vec1",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  9);
    step("mb_vec2",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  10);
    step("mb_run",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  10);
    // mem_busy inside VEC_BUSY freezes and holds the iteration counter.
    step("vf_0",     1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, O_VEC,  10);
    step("vf_frz",   1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 11);
    step("vf_1",     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  12);
    step("vf_2",     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  13);
    // Single-cycle vector op (vec_cycles=1) is plain RUN.
    step("vec1",     1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, O_RUN,  13);
    step("vec1_nx",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  13);
    // load_use beats branch_taken; then branch alone flushes IF/ID and ID/EX.
    step("lu_br",    1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, O_HZ,   13);
    step("br",       1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, O_BR,   14);
    step("br_nx",    1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  14);
    // Halt: halt cycle, three drain cycles, then HALTED; start ignored.
    step("halt",     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, O_HZ,   14);
    step("drain_0",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_HZ,   15);
    step("drain_1",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_HZ,   15);
    step("drain_2",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_HZ,   15);
    step("halted",   1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_HALT, 15);
    step("halted_2", 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, O_HALT, 15);

    // Reset, start, then reset again in the middle of a 6-cycle vector op.
    reset = 1'b1;
    #1;
    sb_q.push_back('{O_ZERO, 0, "rst_halted"});
    compare_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("r_start",  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("r_vec0",   1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, O_VEC,  0);
    step("r_vec1",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  1);
    step("r_vec2",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  2);
    step("r_vec3",   1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_VEC,  3);
    // Two VEC_BUSY cycles remain here.
    #1;
    sb_q.push_back('{O_VEC, 4, "r_vec4"});
    compare_now();
    reset = 1'b1;
    #1;
    sb_q.push_back('{O_ZERO, 0, "rst_vec"});
    compare_now();
    @(posedge clk);
    #1;
    sb_q.push_back('{O_ZERO, 0, "rst_vec_hold"});
    compare_now();
    reset = 1'b0;
    step("r_idle0",  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("r_idle1",  1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("r_start2", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_ZERO, 0);
    step("r_run",    1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, O_RUN,  0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
